// File: rtl/mult_operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mult_operand_sequencer_pkg
// Definitions shared by the operand sequencer and the shift-add multiplier top:
// the default operand width, the 3-bit sequencer state encoding and a small
// state-decode helper.
// -----------------------------------------------------------------------------
package mult_operand_sequencer_pkg;

   // Operand width shared by the sequencer and the multiplier datapath.
   localparam int unsigned MULT_DATA_WIDTH = 8;

   // Sequencer states (3-bit encoding shared with the multiplier top).
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_WAIT   = 3'd3,
      ST_OUT    = 3'd4,
      ST_ERR    = 3'd5
   } mult_state_e;

   // True for every state that belongs to an operation in flight or a fault.
   function automatic logic state_is_busy(input mult_state_e st);
      return (st != ST_IDLE);
   endfunction

endpackage : mult_operand_sequencer_pkg

// File: rtl/mult_watchdog.sv
// -----------------------------------------------------------------------------
// mult_watchdog
// Cycle counter guarding the multiplier's completion time.
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous active-high reset
//   clr     : clear the count (asserted in START)
//   en      : count this cycle (asserted in LOAD_B and WAIT)
//   expired : this is the last counted cycle of the TIMEOUT window
// The count holds (cycles elapsed since START) - 1. expired fires on the cycle
// whose registered successor is exactly TIMEOUT cycles after START, so an
// error state entered on that edge appears TIMEOUT cycles after START.
// -----------------------------------------------------------------------------
module mult_watchdog #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned       CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 2);

   logic [CNT_W-1:0] count_r;

   // Cycle counter: clear on START, advance while the multiplier is running.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + 1'b1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = en && (count_r == LAST_CNT);

endmodule : mult_watchdog

// File: rtl/mult_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mult_operand_sequencer
// Feeds operand pairs to a shift-add multiplier over a single shared data bus,
// waits for completion, and hands the product downstream.
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   in_valid/in_ready        : operand pair handshake (in_a, in_b)
//   mult_data, mult_start    : shared operand bus and one-cycle start pulse
//   mult_done, mult_acc/areg : multiplier completion and product halves
//   out_valid/out_ready      : product handshake (out_product = {acc, areg})
//   busy                     : any state other than IDLE
//   err                      : sticky timeout flag, cleared only by reset
// Bus sequence per operation: START (B, start=1), LOAD_B (B), WAIT (A ...).
// All outputs are registered from the next state so they change on the edge
// that enters a state; in particular in_ready stays low during reset and
// rises on the first edge after release.
// -----------------------------------------------------------------------------
module mult_operand_sequencer
   import mult_operand_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MULT_DATA_WIDTH,
   parameter int unsigned TIMEOUT    = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_a,
   input  logic [DATA_WIDTH-1:0]     in_b,
   output logic [DATA_WIDTH-1:0]     mult_data,
   output logic                      mult_start,
   input  logic                      mult_done,
   input  logic [DATA_WIDTH-1:0]     mult_acc,
   input  logic [DATA_WIDTH-1:0]     mult_areg,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*DATA_WIDTH-1:0]   out_product,
   output logic                      busy,
   output logic                      err
);

   mult_state_e               state_r;
   mult_state_e               next_state_s;
   logic [DATA_WIDTH-1:0]     a_r;
   logic [DATA_WIDTH-1:0]     b_r;
   logic                      in_ready_r;
   logic                      mult_start_r;
   logic [DATA_WIDTH-1:0]     mult_data_r;
   logic [DATA_WIDTH-1:0]     mult_data_next_s;
   logic                      out_valid_r;
   logic [2*DATA_WIDTH-1:0]   out_product_r;
   logic                      busy_r;
   logic                      err_r;
   logic                      accept_s;
   logic                      capture_s;
   logic                      wd_clr_s;
   logic                      wd_en_s;
   logic                      wd_expired_s;

   // in_ready_r is high exactly when the FSM sits in IDLE (outside reset).
   assign accept_s = in_valid && in_ready_r;

   mult_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .clr     (wd_clr_s),
      .en      (wd_en_s),
      .expired (wd_expired_s)
   );

   // Next-state and control decode.
   always_comb begin
      next_state_s = state_r;
      wd_clr_s     = 1'b0;
      wd_en_s      = 1'b0;
      capture_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_START;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            wd_clr_s     = 1'b1;
            next_state_s = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            wd_en_s      = 1'b1;
            next_state_s = ST_WAIT;
         end
         ST_WAIT: begin
            wd_en_s = 1'b1;
            // A completion on the final window cycle still counts as success.
            if (mult_done) begin
               capture_s    = 1'b1;
               next_state_s = ST_OUT;
            end else if (wd_expired_s) begin
               next_state_s = ST_ERR;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_OUT;
            end
         end
         ST_ERR: begin
            next_state_s = ST_ERR;
         end
         default: begin
            next_state_s = ST_ERR;
         end
      endcase
   end

   // Operand bus value for the state being entered; START takes B straight
   // from the input because b_r loads on the same edge.
   always_comb begin
      mult_data_next_s = {DATA_WIDTH{1'b0}};
      case (next_state_s)
         ST_START:  mult_data_next_s = in_b;
         ST_LOAD_B: mult_data_next_s = b_r;
         ST_WAIT:   mult_data_next_s = a_r;
         default:   mult_data_next_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // State, operand and registered-output update.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r       <= ST_IDLE;
         a_r           <= {DATA_WIDTH{1'b0}};
         b_r           <= {DATA_WIDTH{1'b0}};
         in_ready_r    <= 1'b0;
         mult_start_r  <= 1'b0;
         mult_data_r   <= {DATA_WIDTH{1'b0}};
         out_valid_r   <= 1'b0;
         out_product_r <= {(2*DATA_WIDTH){1'b0}};
         busy_r        <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (accept_s) begin
            a_r <= in_a;
            b_r <= in_b;
         end
         if (capture_s) begin
            out_product_r <= {mult_acc, mult_areg};
         end
         in_ready_r   <= (next_state_s == ST_IDLE);
         mult_start_r <= (next_state_s == ST_START);
         mult_data_r  <= mult_data_next_s;
         out_valid_r  <= (next_state_s == ST_OUT);
         busy_r       <= state_is_busy(next_state_s);
         err_r        <= (next_state_s == ST_ERR);
      end
   end

   assign in_ready    = in_ready_r;
   assign mult_start  = mult_start_r;
   assign mult_data   = mult_data_r;
   assign out_valid   = out_valid_r;
   assign out_product = out_product_r;
   assign busy        = busy_r;
   assign err         = err_r;

endmodule : mult_operand_sequencer

// File: tb/tb_mult_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_operand_sequencer
// Self-checking bench. The bench plays the multiplier: it expects B,B,A,... on
// the operand bus and answers with {acc, areg} = A*B computed arithmetically.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mult_operand_sequencer;

   localparam int DW = 8;
   localparam int TO = 32;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_a;
   logic [DW-1:0]   in_b;
   logic [DW-1:0]   mult_data;
   logic            mult_start;
   logic            mult_done;
   logic [DW-1:0]   mult_acc;
   logic [DW-1:0]   mult_areg;
   logic            out_valid;
   logic            out_ready;
   logic [2*DW-1:0] out_product;
   logic            busy;
   logic            err;

   int              n_tests = 0;
   int              n_fail  = 0;
   logic [2*DW-1:0] last_product = 16'h0000;

   mult_operand_sequencer #(
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mult_data   (mult_data),
      .mult_start  (mult_start),
      .mult_done   (mult_done),
      .mult_acc    (mult_acc),
      .mult_areg   (mult_areg),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy),
      .err         (err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(negedge i_clk);
   endtask

   // All reset-time outputs (including in_ready) low.
   task automatic check_all_zero(input string tag);
      n_tests++;
      if ({mult_start, mult_data, out_valid, out_product, busy, err, in_ready} !== '0) begin
         n_fail++;
         $display("FAIL %s: start=%b data=%h ov=%b prod=%h busy=%b err=%b rdy=%b, required all 0",
                  tag, mult_start, mult_data, out_valid, out_product, busy, err, in_ready);
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_ready: in_ready=%b, required 1 within 20 cycles", in_ready);
      end
   endtask

   // One complete operation: done_k = cycle after START at which done pulses,
   // bp = cycles of out_ready low while the product is presented.
   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int done_k, input int bp);
      logic [2*DW-1:0] exp;
      bit              ok;
      exp = {8'h00, a} * {8'h00, b};
      wait_ready(ok);
      if (!ok) return;
      n_tests++;
      if (busy !== 1'b0 || mult_data !== 8'h00) begin
         n_fail++;
         $display("FAIL idle_outputs: busy=%b data=%h, required 0/00", busy, mult_data);
      end
      in_valid = 1'b1; in_a = a; in_b = b;
      tick();
      in_valid = 1'b0; in_a = DW'($urandom); in_b = DW'($urandom);
      n_tests++;
      if (mult_start !== 1'b1 || mult_data !== b || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_cycle: start=%b data=%h rdy=%b busy=%b, required 1/%h/0/1",
                  mult_start, mult_data, in_ready, busy, b);
      end
      tick();
      n_tests++;
      if (mult_start !== 1'b0 || mult_data !== b) begin
         n_fail++;
         $display("FAIL load_b_cycle: start=%b data=%h, required 0/%h", mult_start, mult_data, b);
      end
      for (int k = 2; k <= done_k; k++) begin
         tick();
         n_tests++;
         if (mult_data !== a || out_valid !== 1'b0 || mult_start !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_cycle%0d: data=%h ov=%b start=%b err=%b, required %h/0/0/0",
                     k, mult_data, out_valid, mult_start, err, a);
         end
         if (k == done_k) begin
            mult_done = 1'b1; mult_acc = exp[15:8]; mult_areg = exp[7:0];
         end
      end
      tick();
      mult_done = 1'b0; mult_acc = DW'($urandom); mult_areg = DW'($urandom);
      n_tests++;
      if (out_valid !== 1'b1 || out_product !== exp || busy !== 1'b1 || in_ready !== 1'b0
          || mult_data !== 8'h00 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL out_cycle: ov=%b prod=%h busy=%b rdy=%b data=%h err=%b, required 1/%h/1/0/00/0",
                  out_valid, out_product, busy, in_ready, mult_data, err, exp);
      end
      for (int i = 0; i < bp; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_product !== exp || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure%0d: ov=%b prod=%h rdy=%b, required 1/%h/0",
                     i, out_valid, out_product, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL after_handshake: ov=%b rdy=%b busy=%b, required 0/1/0",
                  out_valid, in_ready, busy);
      end
      last_product = exp;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all_zero("reset_hold");
      end
      i_rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b before first edge, required 0", in_ready);
      end
      tick();
      n_tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b busy=%b, required 1/0", in_ready, busy);
      end
   endtask

   task automatic test_basic();
      run_op(8'd13, 8'd11, 10, 0);
      n_tests++;
      if (out_product !== 16'h008F) begin
         n_fail++;
         $display("FAIL basic_product: got %h, required 008F", out_product);
      end
   endtask

   task automatic test_max();
      run_op(8'd255, 8'd255, 3, 0);
      n_tests++;
      if (out_product !== 16'hFE01) begin
         n_fail++;
         $display("FAIL max_product: got %h, required FE01", out_product);
      end
   endtask

   task automatic test_backpressure();
      run_op(8'd200, 8'd7, 4, 5);
   endtask

   task automatic test_done_at_limit();
      // Last cycle of the window: capture must win over the timeout.
      run_op(8'd99, 8'd3, TO - 1, 1);
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL done_at_limit: err=%b, required 0", err);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         run_op(DW'($urandom), DW'($urandom), $urandom_range(TO - 1, 2), $urandom_range(3, 0));
      end
   endtask

   task automatic test_stray_done();
      mult_done = 1'b1; mult_acc = 8'hA5; mult_areg = 8'h5A;
      tick();
      mult_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_product !== last_product) begin
            n_fail++;
            $display("FAIL stray_done%0d: ov=%b busy=%b rdy=%b prod=%h, required 0/0/1/%h",
                     i, out_valid, busy, in_ready, out_product, last_product);
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < TO; k++) begin
         tick();
         n_tests++;
         if (err !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early%0d: err=%b ov=%b, required 0/0", k, err, out_valid);
         end
      end
      tick();
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0
          || mult_data !== 8'h00 || mult_start !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_err: err=%b busy=%b rdy=%b ov=%b data=%h start=%b, required 1/1/0/0/00/0",
                  err, busy, in_ready, out_valid, mult_data, mult_start);
      end
      in_valid = 1'b1; mult_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (err !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky%0d: err=%b rdy=%b ov=%b, required 1/0/0", i, err, in_ready, out_valid);
         end
      end
      in_valid = 1'b0; mult_done = 1'b0;
   endtask

   task automatic test_abort();
      bit ok;
      // Leave ERR through reset.
      i_rst = 1'b1;
      #1;
      check_all_zero("reset_from_err");
      tick();
      i_rst = 1'b0;
      tick();
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1; in_a = 8'd44; in_b = 8'd9;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      n_tests++;
      if (mult_data !== 8'd44) begin
         n_fail++;
         $display("FAIL abort_in_wait: data=%h, required 2c", mult_data);
      end
      i_rst = 1'b1;
      #1;
      check_all_zero("abort_immediate");
      tick();
      check_all_zero("abort_hold");
      i_rst = 1'b0;
      tick();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_recover: rdy=%b ov=%b busy=%b, required 1/0/0", in_ready, out_valid, busy);
      end
      last_product = 16'h0000;
      run_op(8'd0, 8'd77, 5, 1);
      n_tests++;
      if (out_product !== 16'h0000) begin
         n_fail++;
         $display("FAIL abort_next_product: got %h, required 0000", out_product);
      end
   endtask

   initial begin
      i_rst     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 8'h00;
      in_b      = 8'h00;
      mult_done = 1'b0;
      mult_acc  = 8'h00;
      mult_areg = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_stray_done();
      test_basic();
      test_max();
      test_backpressure();
      test_done_at_limit();
      test_back_to_back();
      test_stray_done();
      test_timeout();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mult_operand_sequencer
